// File: rtl/promedio_adc_if.sv
// rtl/promedio_adc_if.sv - frame bus between the ADC capture stage, the averager and the offset stage
interface promedio_adc_if;
    logic        CS;
    logic [15:0] DinParalelo;
    logic [15:0] Dato_OUT;
    logic        Listo;
    logic [7:0]  Descartes;

    modport master (
        output CS,
        output DinParalelo,
        input  Dato_OUT,
        input  Listo,
        input  Descartes
    );

    modport slave (
        input  CS,
        input  DinParalelo,
        output Dato_OUT,
        output Listo,
        output Descartes
    );
endinterface

// File: rtl/promedio_adc.sv
// rtl/promedio_adc.sv - oversampling ADC averager; PROMEDIO_REDONDEO_EN selects round-half-up over truncation
module promedio_adc #(
    parameter int LOG2N = 2,
    parameter int DW    = 12
) (
    input  logic           CLK,
    input  logic           Reset,
    promedio_adc_if.slave  bus
);
    localparam int AW = DW + LOG2N;
    localparam int CW = LOG2N + 1;
    localparam int NS = 2 ** LOG2N;
`ifdef PROMEDIO_REDONDEO_EN
    localparam int BIAS = NS / 2;
`else
    localparam int BIAS = 0;
`endif
    localparam logic [15:0] PROT_MASK = ~((16'd1 << DW) - 16'd1);

    typedef enum logic [1:0] {ESPERA, EVALUA, SALIDA} estado_t;

    estado_t       state_q, state_d;
    logic          cs_sync1_q, cs_sync2_q, cs_sync3_q;
    logic [15:0]   frame_q, frame_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   dato_q, dato_d;
    logic          listo_q, listo_d;
    logic [7:0]    descartes_q, descartes_d;

    logic          evento;
    logic          proto_bad;
    logic [DW-1:0] sample;
    logic [AW-1:0] acc_sum;
    logic [AW-1:0] redondeado;
    logic [DW-1:0] media;
    logic [CW-1:0] count_inc;

    assign evento     = cs_sync2_q & ~cs_sync3_q;
    assign proto_bad  = |(frame_q & PROT_MASK);
    assign sample     = frame_q[DW-1:0];
    assign acc_sum    = acc_q + AW'(sample);
    // The largest possible sum plus bias still fits in AW bits, so no carry is lost.
    assign redondeado = acc_sum + AW'(BIAS);
    assign media      = redondeado[AW-1:LOG2N];
    assign count_inc  = count_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        acc_d       = acc_q;
        count_d     = count_q;
        dato_d      = dato_q;
        listo_d     = 1'b0;
        descartes_d = descartes_q;
        case (state_q)
            ESPERA: begin
                if (evento) begin
                    frame_d = bus.DinParalelo;
                    state_d = EVALUA;
                end
            end
            EVALUA: begin
                if (proto_bad) begin
                    if (descartes_q != 8'hFF) begin
                        descartes_d = descartes_q + 8'd1;
                    end
                    state_d = ESPERA;
                end else begin
                    acc_d   = acc_sum;
                    count_d = count_inc;
                    if (count_inc == CW'(NS)) begin
                        dato_d  = 16'(media);
                        listo_d = 1'b1;
                        state_d = SALIDA;
                    end else begin
                        state_d = ESPERA;
                    end
                end
            end
            SALIDA: begin
                acc_d   = '0;
                count_d = '0;
                state_d = ESPERA;
            end
            default: state_d = ESPERA;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q     <= ESPERA;
            cs_sync1_q  <= 1'b0;
            cs_sync2_q  <= 1'b0;
            cs_sync3_q  <= 1'b0;
            frame_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            dato_q      <= '0;
            listo_q     <= 1'b0;
            descartes_q <= '0;
        end else begin
            state_q     <= state_d;
            cs_sync1_q  <= bus.CS;
            cs_sync2_q  <= cs_sync1_q;
            cs_sync3_q  <= cs_sync2_q;
            frame_q     <= frame_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            dato_q      <= dato_d;
            listo_q     <= listo_d;
            descartes_q <= descartes_d;
        end
    end

    assign bus.Dato_OUT  = dato_q;
    assign bus.Listo     = listo_q;
    assign bus.Descartes = descartes_q;
endmodule

// File: tb/tb_promedio_adc.sv
// tb/tb_promedio_adc.sv - bench for promedio_adc with LOG2N=2 and LOG2N=0 instances driven in parallel
module tb_promedio_adc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    promedio_adc_if b2();
    promedio_adc_if b0();

    promedio_adc #(.LOG2N(2), .DW(12)) dut2 (.CLK(clk), .Reset(rst_n), .bus(b2));
    promedio_adc #(.LOG2N(0), .DW(12)) dut0 (.CLK(clk), .Reset(rst_n), .bus(b0));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int rst_at = -1;
    int obs_listo[2] = '{0, 0};

    int m_log2n[2] = '{2, 0};
    int m_sum[2];
    int m_cnt[2];
    int m_dato[2];
    int m_desc[2];
    bit m_listo[2];

    int          pend_cyc[$];
    logic [15:0] pend_frame[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_dato[i] = 0; m_desc[i] = 0; m_listo[i] = 1'b0;
        end
    endfunction

    function automatic void model_apply(input logic [15:0] f);
        int n;
        int bias;
        for (int i = 0; i < 2; i++) begin
            n = 1 << m_log2n[i];
`ifdef PROMEDIO_REDONDEO_EN
            bias = n / 2;
`else
            bias = 0;
`endif
            if ((f >> 12) != 0) begin
                if (m_desc[i] < 255) m_desc[i]++;
            end else begin
                m_sum[i] += int'(f);
                m_cnt[i]++;
                if (m_cnt[i] == n) begin
                    m_dato[i]  = (m_sum[i] + bias) / n;
                    m_listo[i] = 1'b1;
                    m_sum[i]   = 0;
                    m_cnt[i]   = 0;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            m_listo[0] = 1'b0;
            m_listo[1] = 1'b0;
            if (rst_at == cyc) begin
                model_clear();
                pend_cyc.delete();
                pend_frame.delete();
            end
            while (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
                model_apply(pend_frame[0]);
                void'(pend_cyc.pop_front());
                void'(pend_frame.pop_front());
            end
            check("listo_n4", int'(b2.Listo), int'(m_listo[0]));
            check("dato_n4", int'(b2.Dato_OUT), m_dato[0]);
            check("desc_n4", int'(b2.Descartes), m_desc[0]);
            check("listo_n1", int'(b0.Listo), int'(m_listo[1]));
            check("dato_n1", int'(b0.Dato_OUT), m_dato[1]);
            check("desc_n1", int'(b0.Descartes), m_desc[1]);
            if (b2.Listo === 1'b1) obs_listo[0]++;
            if (b0.Listo === 1'b1) obs_listo[1]++;
        end
    end

    // Effects of a CS rise become visible 4 edges later: 2 sync flops, then EVALUA, then SALIDA.
    task automatic send(input logic [15:0] f, input int hi, input int lo);
        @(posedge clk); #1;
        b2.DinParalelo = f; b0.DinParalelo = f;
        b2.CS = 1'b1;       b0.CS = 1'b1;
        pend_cyc.push_back(cyc + 4);
        pend_frame.push_back(f);
        repeat (hi) @(posedge clk);
        #1;
        b2.CS = 1'b0; b0.CS = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        rst_at = cyc + 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int base2, base0;
    logic [15:0] rf;

    initial begin
        b2.CS = 1'b0; b0.CS = 1'b0;
        b2.DinParalelo = '0; b0.DinParalelo = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        #2;
        check("reset_dato", int'(b2.Dato_OUT), 0);
        check("reset_listo", int'(b2.Listo), 0);
        check("reset_desc", int'(b2.Descartes), 0);

        // Four-sample mean
        base2 = obs_listo[0]; base0 = obs_listo[1];
        send(16'h0064, 3, 3); send(16'h0065, 4, 3); send(16'h0066, 3, 5); send(16'h0067, 3, 3);
        settle();
`ifdef PROMEDIO_REDONDEO_EN
        check("t1_mean", int'(b2.Dato_OUT), 'h0066);
`else
        check("t1_mean", int'(b2.Dato_OUT), 'h0065);
`endif
        check("t1_listo_cnt", obs_listo[0] - base2, 1);
        check("t1_pass_cnt", obs_listo[1] - base0, 4);
        check("t1_pass_last", int'(b0.Dato_OUT), 'h0067);

        // Rejected frame in the middle of a group
        base2 = obs_listo[0];
        send(16'h0010, 3, 3); send(16'h0010, 3, 3); send(16'hF123, 3, 3);
        send(16'h0010, 3, 3); send(16'h0010, 3, 3);
        settle();
        check("t2_desc", int'(b2.Descartes), 1);
        check("t2_mean", int'(b2.Dato_OUT), 'h0010);
        check("t2_listo_cnt", obs_listo[0] - base2, 1);

        // Reset discards a partial sum
        send(16'h0200, 3, 3); send(16'h0200, 3, 3);
        settle();
        do_reset();
        #2;
        check("t3_rst_dato", int'(b2.Dato_OUT), 0);
        check("t3_rst_desc", int'(b2.Descartes), 0);
        check("t3_rst_dato1", int'(b0.Dato_OUT), 0);
        base2 = obs_listo[0];
        repeat (4) send(16'h0FFF, 3, 3);
        settle();
        check("t3_mean", int'(b2.Dato_OUT), 'h0FFF);
        check("t3_listo_cnt", obs_listo[0] - base2, 1);

        // Long CS high produces a single event
        base2 = obs_listo[0]; base0 = obs_listo[1];
        send(16'h0100, 1000, 5);
        send(16'h0100, 6, 5);
        settle();
        check("t4_pass_cnt", obs_listo[1] - base0, 2);
        check("t4_listo_cnt", obs_listo[0] - base2, 0);

        // Saturating reject counter
        base2 = obs_listo[0]; base0 = obs_listo[1];
        repeat (300) send(16'h8000, 3, 3);
        settle();
        check("t5_desc_n4", int'(b2.Descartes), 255);
        check("t5_desc_n1", int'(b0.Descartes), 255);
        check("t5_no_listo", (obs_listo[0] - base2) + (obs_listo[1] - base0), 0);

        // Random frames, roughly one in five rejected
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 4) == 0)
                rf = {4'($urandom_range(1, 15)), 12'($urandom)};
            else
                rf = {4'h0, 12'($urandom)};
            send(rf, $urandom_range(3, 8), $urandom_range(3, 8));
        end
        settle();

        // Pass-through instance
        base0 = obs_listo[1];
        send(16'h0ABC, 3, 3);
        settle();
        check("t6_first", int'(b0.Dato_OUT), 'h0ABC);
        send(16'h0123, 3, 3);
        settle();
        check("t6_second", int'(b0.Dato_OUT), 'h0123);
        check("t6_listo_cnt", obs_listo[1] - base0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/promedio_adc.md
Name: promedio_adc

Overview:
Oversampling averager between the serial ADC capture stage and the input offset stage of the PI-D loop. It takes each completed 16-bit ADC frame, checks its 4 protocol bits, and accumulates 2^LOG2N valid 12-bit samples. It then emits their mean in the same 16-bit frame format with a one-cycle Listo strobe. This reduces ADC noise seen by the controller at the cost of a lower effective sample rate.

Parameters:
LOG2N, 2, log2 of samples per average; legal range 0..4; 0 = pass-through of each valid sample.
DW, 12, ADC data bits in DinParalelo[DW-1:0]; the upper 16-DW bits are the protocol field and must be zero.

Ports:
CLK  input  1  system clock; the only clock.
Reset  input  1  synchronous, active-low reset.
CS  input  1  chip-select from capture stage, 4 kHz domain; a rising edge marks DinParalelo as a complete frame.
DinParalelo  input  16  parallel frame from capture stage; stable while CS is high.
Dato_OUT  output  16  averaged frame; [15:DW] = 0, [DW-1:0] = mean.
Listo  output  1  one-CLK pulse when Dato_OUT updates.
Descartes  output  8  saturating count of rejected frames (nonzero protocol bits).

Behaviour:
- Reset (Reset==0 at a CLK edge): Dato_OUT=0, Listo=0, Descartes=0, accumulator=0, sample count=0, sync flops=0, FSM to ESPERA.
- Reset mid-accumulation discards the partial sum; no Listo is produced for it.
- CS is synchronised with 2 flops, plus a third flop for edge detection.
- Evento = sync2 & ~sync3. There is exactly one Evento per CS rising edge, regardless of how long CS stays high.
- FSM states:
  - ESPERA: idle until Evento.
  - On Evento, DinParalelo is sampled in that cycle and the FSM goes to EVALUA.
  - EVALUA (1 cycle):
    - If frame[15:DW]!=0: Descartes += 1, saturating at 255; frame dropped; count and accumulator unchanged; back to ESPERA.
    - Else: acc += frame[DW-1:0]; count += 1.
    - If count reaches 2^LOG2N, go to SALIDA; otherwise go to ESPERA.
  - SALIDA (1 cycle):
    - Dato_OUT <= {zeros, result}; Listo=1 this cycle only.
    - Accumulator and count cleared; back to ESPERA.
- Latency from Evento cycle to Listo: 2 CLK cycles.
- Accumulator width is DW+LOG2N bits and cannot overflow.
- Result = (acc + bias) >> LOG2N, where bias is defined under Optional Feature. The result always fits in DW bits; no saturation logic is needed.
- An Evento arriving while in EVALUA or SALIDA cannot occur at the 4 kHz frame rate. If it does, it is ignored. The state machine must not hang or double-count.
- LOG2N=0: every valid frame produces Listo; result = sample.
- Dato_OUT holds its value between Listo pulses.

Optional Feature:
PROMEDIO_REDONDEO_EN:
- Defined: bias = 2^(LOG2N-1) when LOG2N>0, giving round-half-up.
- Undefined: bias = 0, giving truncation.
- LOG2N=0 behaves identically with or without the macro.

Test Plan:
1. LOG2N=2, frames 0x0064, 0x0065, 0x0066, 0x0067 (CS pulse each) -> one Listo, 2 CLK after the 4th Evento.
   - Dato_OUT=0x0065 without macro; 0x0066 with PROMEDIO_REDONDEO_EN.
2. LOG2N=2, frame 0xF123 between valid frames 0x0010 x4 -> Descartes=1, Dato_OUT=0x0010, exactly one Listo.
3. Reset low for 1 cycle after 2 valid frames, then 4 frames of 0x0FFF -> all outputs 0 after reset; single Listo with Dato_OUT=0x0FFF in both macro builds.
4. CS held high for 1000 CLK, then low, then high again -> exactly 2 Eventos counted; no extra Listo.
5. 300 consecutive frames 0x8000 -> Descartes stays 255 after the 255th; Listo never asserted.
6. LOG2N=0, frames 0x0ABC then 0x0123 -> two Listo pulses with Dato_OUT=0x0ABC, then 0x0123.
